// File: rtl/modem_pkg.sv
// Shared definitions for the multimode modulator: mode codes, FSM states,
// and the offset-binary midpoint helper.
package modem_pkg;

  localparam logic [1:0] MODE_ASK   = 2'b00;
  localparam logic [1:0] MODE_FSK   = 2'b01;
  localparam logic [1:0] MODE_BPSK  = 2'b10;
  localparam logic [1:0] MODE_DBPSK = 2'b11;

  localparam real PI = 3.141592653589793;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  function automatic int unsigned mid_val(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/modem_sine_lut.sv
// Full-wave sine ROM in offset binary, filled at elaboration time.
module modem_sine_lut
  import modem_pkg::*;
#(
  parameter int unsigned LUT_AW = 6,
  parameter int unsigned OUT_W  = 7
) (
  input  logic [LUT_AW-1:0] addr_i,
  output logic [OUT_W-1:0]  sample_o
);

  localparam int unsigned MIDV  = mid_val(OUT_W);
  localparam int unsigned DEPTH = 1 << LUT_AW;

  logic [OUT_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real AMP = real'(MIDV - 1) * $sin(2.0 * PI * real'(k) / real'(DEPTH));
    // Round half away from zero so the table is symmetric about MID.
    localparam int RND = (AMP >= 0.0) ? $rtoi(AMP + 0.5) : -$rtoi(0.5 - AMP);
    localparam int VAL = int'(MIDV) + RND;
    assign rom[k] = VAL[OUT_W-1:0];
  end

  assign sample_o = rom[addr_i];

endmodule

// File: rtl/modem_tx_multi.sv
// UART-framed byte modulator: ASK/FSK/BPSK/DBPSK onto a DDS sine carrier,
// registered offset-binary sample output.
module modem_tx_multi
  import modem_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SPS     = 4,
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned LUT_AW  = 6,
  parameter int unsigned OUT_W   = 7,
  parameter int unsigned F0_INC  = 16,
  parameter int unsigned F1_INC  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [OUT_W-1:0]  sample_out,
  output logic              sym_strobe,
  output logic              busy
);

  localparam int unsigned CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [OUT_W-1:0]   MID  = OUT_W'(mid_val(OUT_W));
  localparam logic [PHASE_W-1:0] HALF = {1'b1, {(PHASE_W-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          mode_q, mode_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                ref_q, ref_d;
  logic [OUT_W-1:0]    sample_q, sample_d;
  logic                strobe_q, strobe_d;

  logic                busy_w, ready_w, xfer, sym_first, sym_last, bit_last;
  logic                cur_bit, ref_eff;
  logic [PHASE_W-1:0]  inc, off, phase_sum;
  logic [LUT_AW-1:0]   lut_addr;
  logic [OUT_W-1:0]    lut_sample;

  modem_sine_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .addr_i   (lut_addr),
    .sample_o (lut_sample)
  );

  always_comb begin
    busy_w    = (state_q != ST_IDLE);
    sym_first = (cnt_q == '0);
    sym_last  = (cnt_q == CW'(SPS - 1));
    bit_last  = (idx_q == BW'(DATA_W - 1));
    ready_w   = (state_q == ST_IDLE) || (state_q == ST_STOP && sym_last);
    xfer      = tx_valid && ready_w;

    cur_bit = 1'b0;
    case (state_q)
      ST_DATA: cur_bit = data_q[idx_q];
      ST_STOP: cur_bit = 1'b1;
      default: cur_bit = 1'b0;
    endcase

    // The toggle for a '1' symbol applies from its first clock onward.
    ref_eff = (sym_first && cur_bit) ? ~ref_q : ref_q;

    inc = (mode_q == MODE_FSK && cur_bit) ? PHASE_W'(F1_INC) : PHASE_W'(F0_INC);
    off = '0;
    if (mode_q == MODE_BPSK && cur_bit)  off = HALF;
    if (mode_q == MODE_DBPSK && ref_eff) off = HALF;
    phase_sum = phase_q + off;
    lut_addr  = LUT_AW'(phase_sum >> (PHASE_W - LUT_AW));

    sample_d = MID;
    if (busy_w) sample_d = (mode_q == MODE_ASK && !cur_bit) ? MID : lut_sample;
    strobe_d = busy_w && sym_first;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    ref_d   = ref_q;

    if (busy_w) begin
      cnt_d   = sym_last ? '0 : cnt_q + 1'b1;
      phase_d = phase_q + inc;
      ref_d   = ref_eff;
    end

    case (state_q)
      ST_START: if (sym_last) begin
        state_d = ST_DATA;
        idx_d   = '0;
      end
      ST_DATA: if (sym_last) begin
        if (bit_last) state_d = ST_STOP;
        else          idx_d   = idx_q + 1'b1;
      end
      ST_STOP: if (sym_last) state_d = ST_IDLE;
      default: ;
    endcase

    // A transfer on the last STOP clock overrides the return to IDLE.
    if (xfer) begin
      state_d = ST_START;
      cnt_d   = '0;
      idx_d   = '0;
      data_d  = tx_data;
      mode_d  = mode;
      phase_d = '0;
      ref_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      mode_q   <= MODE_ASK;
      phase_q  <= '0;
      ref_q    <= 1'b0;
      sample_q <= MID;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      ref_q    <= ref_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
    end
  end

  assign tx_ready   = ready_w;
  assign busy       = busy_w;
  assign sample_out = sample_q;
  assign sym_strobe = strobe_q;

endmodule

// File: tb/tb_modem_tx_multi.sv
// Randomized bench for modem_tx_multi against a frame-level sample-stream model.
module tb_modem_tx_multi;

  localparam int DATA_W = 8;
  localparam int SPS    = 4;
  localparam int OUT_W  = 7;
  localparam int MID    = 64;
  localparam int NCLK   = (DATA_W + 2) * SPS;
  localparam real TWO_PI = 6.283185307179586;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [OUT_W-1:0]  sample_out;
  logic              sym_strobe;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  modem_tx_multi #(
    .DATA_W  (8),
    .SPS     (4),
    .PHASE_W (8),
    .LUT_AW  (6),
    .OUT_W   (7),
    .F0_INC  (16),
    .F1_INC  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .sample_out (sample_out),
    .sym_strobe (sym_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int sine_ref(input int k);
    real v, r;
    v = 63.0 * $sin(TWO_PI * real'(k) / 64.0);
    r = (v >= 0.0) ? $floor(v + 0.5) : -$floor(0.5 - v);
    return MID + $rtoi(r);
  endfunction

  // Expected output stream: one entry (sample*2 + strobe) per clock still to come.
  int exp_q[$];
  int exp_s  = MID;
  int exp_st = 0;
  bit live   = 0;
  bit hs_edge = 0;

  // Whole frame from the framing rules: bit per symbol, phase = sum of
  // increments so far, DBPSK ref = parity of '1' symbols seen so far.
  function automatic void gen_frame(input logic [DATA_W-1:0] d, input logic [1:0] m);
    int ph = 0;
    int ones = 0;
    for (int k = 0; k < NCLK; k++) begin
      int sym = k / SPS;
      int b, off, s;
      b = (sym == 0) ? 0 : (sym <= DATA_W) ? int'(d[sym-1]) : 1;
      if (k % SPS == 0 && b == 1) ones++;
      off = 0;
      if (m == 2'b10 && b == 1) off = 128;
      if (m == 2'b11 && (ones % 2) == 1) off = 128;
      s = (m == 2'b00 && b == 0) ? MID : sine_ref(((ph + off) % 256) / 4);
      exp_q.push_back(s * 2 + ((k % SPS == 0) ? 1 : 0));
      ph = (ph + ((m == 2'b01 && b == 1) ? 32 : 16)) % 256;
    end
  endfunction

  always @(posedge clk) begin
    bit hs;
    int e;
    live    = 1;
    hs_edge = 0;
    if (rst) begin
      exp_q.delete();
      exp_s  = MID;
      exp_st = 0;
    end else begin
      hs = tx_valid && (exp_q.size() <= 1);
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        exp_s  = e / 2;
        exp_st = e % 2;
      end else begin
        exp_s  = MID;
        exp_st = 0;
      end
      if (hs) begin
        gen_frame(tx_data, mode);
        hs_edge = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("sample_out", 32'(sample_out), 32'(exp_s));
      check("sym_strobe", 32'(sym_strobe), 32'(exp_st));
      check("busy", 32'(busy), (exp_q.size() > 0) ? 32'd1 : 32'd0);
      check("tx_ready", 32'(tx_ready), (exp_q.size() <= 1) ? 32'd1 : 32'd0);
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input logic [1:0] m);
    int n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    mode     = m;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!hs_edge && n < 200);
    check("handshake", 32'(hs_edge), 32'd1);
    tx_valid = 1'b0;
    tx_data  = DATA_W'($urandom);
    mode     = 2'($urandom);
  endtask

  task automatic wait_idle();
    repeat (NCLK + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    mode     = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(8'h00, 2'b00); wait_idle();
    send(8'hFF, 2'b01); wait_idle();
    send(8'h01, 2'b10); wait_idle();
    send(8'h03, 2'b11); wait_idle();

    // Back-to-back frames; inputs wander to FSK mid-frame.
    send(8'hA5, 2'b00);
    send(8'h5A, 2'b00);
    mode = 2'b01;
    wait_idle();

    // Reset during the data bits, then a clean frame.
    send(8'h3C, 2'b10);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'hC3, 2'b11); wait_idle();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(DATA_W'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(5, 30)) @(posedge clk);
      #1;
    end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/modem_tx_multi.md
Name: modem_tx_multi

Overview:
Parametrised multimode digital modulator, successor to the fixed 2-bit-select modem datapath. It accepts bytes on a valid/ready handshake and frames each one UART-style. Each symbol is modulated onto a DDS sine carrier as ASK, FSK, BPSK or DBPSK, and the result drives the unsigned sample bus that feeds the pad/DAC outputs. Mode is a per-frame choice; sample width, word width, oversampling and tone increments are generics.

Parameters:
DATA_W, 8, data bits per frame
SPS, 4, clocks per symbol (>=2)
PHASE_W, 8, phase accumulator width
LUT_AW, 6, sine LUT address bits (<=PHASE_W), full-wave table
OUT_W, 7, output sample width
F0_INC, 16, phase increment for carrier / FSK mark-0
F1_INC, 32, phase increment for FSK mark-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mode  in  2  00 ASK, 01 FSK, 10 BPSK, 11 DBPSK; sampled on handshake only
tx_data  in  DATA_W  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept tx_data this cycle
sample_out  out  OUT_W  modulated sample, offset binary
sym_strobe  out  1  one-cycle pulse on first clock of each symbol
busy  out  1  frame in progress

Behaviour:
- Reset: tx_ready=1, busy=0, sym_strobe=0, sample_out=MID (2^(OUT_W-1)), phase=0, FSM IDLE. Reset mid-frame abandons the frame; outputs take reset values on the next edge.
- Handshake: transfer when tx_valid&tx_ready at edge N. tx_data, mode latched; phase cleared to 0; DBPSK ref cleared to 0. Input changes after edge N are ignored until next transfer.
- FSM: IDLE -> START (1 symbol, bit 0) -> DATA (DATA_W symbols, LSB first) -> STOP (1 symbol, bit 1) -> IDLE. Frame = (DATA_W+2)*SPS clocks.
- Symbol counter counts 0..SPS-1. Bit index advances on wrap.
- tx_ready=1 in IDLE and on the last clock of STOP. A transfer on that last STOP clock goes straight to START with no idle gap (back-to-back). Otherwise STOP -> IDLE.
- busy=1 from N+1 through the last STOP clock.
- Phase accumulator: phase += inc every busy clock, mod 2^PHASE_W. inc = F1_INC when mode=FSK and bit=1; otherwise F0_INC.
- LUT index = (phase + off)[PHASE_W-1 -: LUT_AW]:
  - BPSK: off = 2^(PHASE_W-1) when bit=1, else 0.
  - DBPSK: ref toggles at the start of each symbol whose bit=1; off = ref ? 2^(PHASE_W-1) : 0.
- LUT(k) = MID + round((MID-1)*sin(2*pi*k/2^LUT_AW)).
- ASK: bit=0 -> MID; bit=1 -> LUT.
- sample_out is registered; it reflects the FSM state of the previous clock. The first start-bit sample appears at edge N+2. In IDLE, sample_out=MID.
- sym_strobe is aligned with sample_out, not with the FSM (also one cycle after the FSM).
- mode=11 during STOP of a DBPSK frame has no effect until the next handshake.

Decomposition:
- Package modem_pkg: mode encoding constants (MODE_ASK/FSK/BPSK/DBPSK), FSM state enum, MID function of OUT_W.
- Sub-module modem_sine_lut (params LUT_AW, OUT_W). Combinational full-wave ROM generated at elaboration; the registered output stays in modem_tx_multi.

Test Plan:
- Reset during DATA of a frame -> next cycle sample_out=64, busy=0, tx_ready=1; a new frame sends cleanly afterwards.
- ASK, tx_data=0x00, default params -> 36 samples of 64 (start + 8 zero bits), then stop-bit samples 127,... (phase 64 at frame clock 36); busy low after clock 40.
- FSK, 0xFF -> start-bit phases 0,16,32,48; first data sample 127 (phase 64), then phases step by 32; sym_strobe every 4 clocks, 10 pulses total.
- BPSK, 0x01 -> start samples 64 then rising; first data sample 1 (phase 64+128); bits 1..7 use non-inverted carrier.
- DBPSK, 0x03 -> inversion begins at bit0 and flips back at bit1; bits 2..7 stay at the ref left by bit1; ref is cleared for the next frame.
- Back-to-back: hold tx_valid with 0xA5 then 0x5A -> second handshake on the last STOP clock; no MID gap between frames. Mode change mid-frame from ASK to FSK is ignored.
